// File: rtl/des_dpc_px.sv
// DES round core, ROUNDS_PER_CLK rounds per cycle; result registered 16/ROUNDS_PER_CLK cycles after accept, ready only when idle or on the last round.
// DES_DPC_PX_KEYLATCH_EN: latch i_keyex at accept so the key may change mid-block; otherwise i_keyex is used live.
module des_sbox1 (input logic [5:0] i_a, output logic [3:0] o_s);
    localparam logic [255:0] T = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    logic [5:0] idx;
    assign idx = {i_a[5], i_a[0], i_a[4:1]};
    assign o_s = T[{~idx, 2'b11} -: 4];
endmodule

module des_sbox2 (input logic [5:0] i_a, output logic [3:0] o_s);
    localparam logic [255:0] T = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    logic [5:0] idx;
    assign idx = {i_a[5], i_a[0], i_a[4:1]};
    assign o_s = T[{~idx, 2'b11} -: 4];
endmodule

module des_sbox3 (input logic [5:0] i_a, output logic [3:0] o_s);
    localparam logic [255:0] T = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    logic [5:0] idx;
    assign idx = {i_a[5], i_a[0], i_a[4:1]};
    assign o_s = T[{~idx, 2'b11} -: 4];
endmodule

module des_sbox4 (input logic [5:0] i_a, output logic [3:0] o_s);
    localparam logic [255:0] T = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    logic [5:0] idx;
    assign idx = {i_a[5], i_a[0], i_a[4:1]};
    assign o_s = T[{~idx, 2'b11} -: 4];
endmodule

module des_sbox5 (input logic [5:0] i_a, output logic [3:0] o_s);
    localparam logic [255:0] T = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    logic [5:0] idx;
    assign idx = {i_a[5], i_a[0], i_a[4:1]};
    assign o_s = T[{~idx, 2'b11} -: 4];
endmodule

module des_sbox6 (input logic [5:0] i_a, output logic [3:0] o_s);
    localparam logic [255:0] T = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    logic [5:0] idx;
    assign idx = {i_a[5], i_a[0], i_a[4:1]};
    assign o_s = T[{~idx, 2'b11} -: 4];
endmodule

module des_sbox7 (input logic [5:0] i_a, output logic [3:0] o_s);
    localparam logic [255:0] T = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    logic [5:0] idx;
    assign idx = {i_a[5], i_a[0], i_a[4:1]};
    assign o_s = T[{~idx, 2'b11} -: 4];
endmodule

module des_sbox8 (input logic [5:0] i_a, output logic [3:0] o_s);
    localparam logic [255:0] T = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
    logic [5:0] idx;
    assign idx = {i_a[5], i_a[0], i_a[4:1]};
    assign o_s = T[{~idx, 2'b11} -: 4];
endmodule

module des_dpc_px #(
    parameter int ROUNDS_PER_CLK = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_flag,
    input  logic [767:0] i_keyex,
    input  logic [63:0]  i_din,
    input  logic         i_din_en,
    output logic         o_din_rdy,
    output logic [63:0]  o_dout,
    output logic         o_dout_en,
    output logic         o_busy
);
    localparam int ITER = 16 / ROUNDS_PER_CLK;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    if (!(ROUNDS_PER_CLK == 1 || ROUNDS_PER_CLK == 2 || ROUNDS_PER_CLK == 4 ||
          ROUNDS_PER_CLK == 8 || ROUNDS_PER_CLK == 16)) begin : g_bad_rpc
        $error("des_dpc_px: ROUNDS_PER_CLK must be 1, 2, 4, 8 or 16");
    end

    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T [48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                 16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32]  = '{16,7,20,21, 29,12,28,17, 1,15,23,26, 5,18,31,10,
                                 2,8,24,14, 32,27,3,9, 19,13,30,6, 22,11,4,25};

    // Tables use DES bit numbering: bit 1 is the MSB.
    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] e_exp(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
        return y;
    endfunction

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   l_q, r_q;
    logic          mode_q;
    logic [63:0]   dout_q;
    logic          dout_en_q;
    logic          last_d, accept_d;
    logic [767:0]  key_d;

    assign last_d    = (state_q == RUN) && (cnt_q == CW'(ITER - 1));
    assign o_din_rdy = (state_q == IDLE) || last_d;
    assign accept_d  = i_din_en && o_din_rdy;

`ifdef DES_DPC_PX_KEYLATCH_EN
    logic [767:0] key_q;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)         key_q <= '0;
        else if (accept_d) key_q <= i_keyex;
    end
    assign key_d = key_q;
`else
    assign key_d = i_keyex;
`endif

    logic [47:0] ks [16];
    for (genvar n = 0; n < 16; n++) begin : g_ks
        assign ks[n] = key_d[767-48*n -: 48];
    end

    logic [31:0] l_c [ROUNDS_PER_CLK+1];
    logic [31:0] r_c [ROUNDS_PER_CLK+1];
    assign l_c[0] = l_q;
    assign r_c[0] = r_q;

    for (genvar j = 0; j < ROUNDS_PER_CLK; j++) begin : g_rnd
        logic [4:0]  k;
        logic [3:0]  sel;
        logic [47:0] x;
        logic [31:0] s;
        assign k   = 5'(cnt_q) * 5'(ROUNDS_PER_CLK) + 5'(j);
        // Decrypt walks the same schedule backwards: K16 first.
        assign sel = mode_q ? k[3:0] : 4'd15 - k[3:0];
        assign x   = e_exp(r_c[j]) ^ ks[sel];
        des_sbox1 u_s1 (.i_a(x[47:42]), .o_s(s[31:28]));
        des_sbox2 u_s2 (.i_a(x[41:36]), .o_s(s[27:24]));
        des_sbox3 u_s3 (.i_a(x[35:30]), .o_s(s[23:20]));
        des_sbox4 u_s4 (.i_a(x[29:24]), .o_s(s[19:16]));
        des_sbox5 u_s5 (.i_a(x[23:18]), .o_s(s[15:12]));
        des_sbox6 u_s6 (.i_a(x[17:12]), .o_s(s[11:8]));
        des_sbox7 u_s7 (.i_a(x[11:6]),  .o_s(s[7:4]));
        des_sbox8 u_s8 (.i_a(x[5:0]),   .o_s(s[3:0]));
        assign l_c[j+1] = r_c[j];
        assign r_c[j+1] = l_c[j] ^ p_perm(s);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            l_q       <= '0;
            r_q       <= '0;
            mode_q    <= 1'b0;
            dout_q    <= '0;
            dout_en_q <= 1'b0;
        end else begin
            dout_en_q <= 1'b0;
            if (state_q == RUN) begin
                l_q   <= l_c[ROUNDS_PER_CLK];
                r_q   <= r_c[ROUNDS_PER_CLK];
                cnt_q <= last_d ? '0 : cnt_q + CW'(1);
                if (last_d) begin
                    dout_q    <= fp_perm({r_c[ROUNDS_PER_CLK], l_c[ROUNDS_PER_CLK]});
                    dout_en_q <= 1'b1;
                    state_q   <= IDLE;
                end
            end
            // A new block may load on the same edge that retires the previous one.
            if (accept_d) begin
                {l_q, r_q} <= ip_perm(i_din);
                mode_q     <= i_flag;
                cnt_q      <= '0;
                state_q    <= RUN;
            end
        end
    end

    assign o_dout    = dout_q;
    assign o_dout_en = dout_en_q;
    assign o_busy    = (state_q == RUN);
endmodule

// File: tb/tb_des_dpc_px.sv
// Bench for des_dpc_px: one instance per legal ROUNDS_PER_CLK, checked against a result/latency scoreboard.
module tb_des_dpc_px;
    localparam int NI = 5;
    localparam int RL [NI] = '{1, 2, 4, 8, 16};
    localparam logic [63:0] PT = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT = 64'h85E813540F0AB405;
    localparam logic [767:0] KEYS = 768'h1B02EFFC7072_79AED9DBC9E5_55FC8A42CF99_72ADD6DB351D_7CEC07EB53A8_63A53E507B2F_EC84B7F618BC_F78A3AC13BFB_E0DBEBEDE781_B1F347BA464F_215FD3DED386_7571F59467E9_97C5D1FABA41_5F43B7F2E73A_BF918D3D3F0A_CB3D8B0E17F5;

    logic         clk = 1'b0;
    logic         rst;
    logic [767:0] keyex;
    logic         flag   [NI];
    logic [63:0]  din    [NI];
    logic         din_en [NI];
    logic         rdy    [NI];
    logic [63:0]  dout   [NI];
    logic         dout_en[NI];
    logic         busy   [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        des_dpc_px #(.ROUNDS_PER_CLK(RL[g])) u_dut (
            .i_clk(clk), .i_rst(rst), .i_flag(flag[g]), .i_keyex(keyex),
            .i_din(din[g]), .i_din_en(din_en[g]), .o_din_rdy(rdy[g]),
            .o_dout(dout[g]), .o_dout_en(dout_en[g]), .o_busy(busy[g]));
    end

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int idx; logic [63:0] val; int cyc;} sb_t;
    sb_t sb_q[$];

    typedef struct {int idx; logic flag; logic [63:0] din; logic [63:0] exp;} vec_t;
    vec_t vt[2*NI];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        sb_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (dout_en[i] === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_dout_en inst %0d: got %h, required no output", i, dout[i]);
                    end else begin
                        e = sb_q.pop_front();
                        chk($sformatf("dout_inst%0d", i), dout[i], e.val);
                        chk($sformatf("latency_inst%0d", i), 64'(cyc), 64'(e.cyc));
                        chk($sformatf("src_inst%0d", i), 64'(i), 64'(e.idx));
                    end
                end
            end
        end
    endtask

    // Drive a block and wait for it to be taken; returns the cycle number of the accept edge.
    task automatic send(input int i, input logic [63:0] d, input logic f, input logic [63:0] e, output int acc);
        int t;
        t = 0;
        acc = -1;
        @(negedge clk);
        din_en[i] = 1'b1;
        din[i]    = d;
        flag[i]   = f;
        while (rdy[i] !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (rdy[i] !== 1'b1) begin
            chk($sformatf("accept_timeout_inst%0d", i), {63'd0, rdy[i]}, 64'd1);
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            sb_q.push_back('{i, e, cyc + 16 / RL[i]});
        end
    endtask

    task automatic idle(input int i);
        @(negedge clk);
        din_en[i] = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0) begin
            chk("drain_timeout_pending", 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int a0, a1, a2;
        for (int i = 0; i < NI; i++) begin
            vt[2*i]   = '{i, 1'b1, PT, CT};
            vt[2*i+1] = '{i, 1'b0, CT, PT};
            din_en[i] = 1'b0;
            din[i]    = '0;
            flag[i]   = 1'b0;
        end
        keyex = KEYS;
        rst   = 1'b1;
        fork monitor(); join_none

        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_dout_%0d", i), dout[i], 64'd0);
            chk($sformatf("rst_dout_en_%0d", i), {63'd0, dout_en[i]}, 64'd0);
            chk($sformatf("rst_busy_%0d", i), {63'd0, busy[i]}, 64'd0);
            chk($sformatf("rst_rdy_%0d", i), {63'd0, rdy[i]}, 64'd1);
        end
        rst = 1'b0;

        // Encrypt/decrypt on every unroll factor.
        for (int v = 0; v < 2 * NI; v++) begin
            send(vt[v].idx, vt[v].din, vt[v].flag, vt[v].exp, a0);
            idle(vt[v].idx);
            drain();
        end

        // Back-to-back at 4 rounds/clk, mixed modes.
        send(2, PT, 1'b1, CT, a0);
        send(2, CT, 1'b0, PT, a1);
        send(2, PT, 1'b1, CT, a2);
        idle(2);
        chk("b2b_r4_gap_ab", 64'(a1 - a0), 64'd4);
        chk("b2b_r4_gap_bc", 64'(a2 - a1), 64'd4);
        drain();

        // Fully unrolled: a block every cycle, ready never drops.
        send(4, PT, 1'b1, CT, a0);
        chk("r16_rdy_held", {63'd0, rdy[4]}, 64'd1);
        send(4, CT, 1'b0, PT, a1);
        chk("r16_rdy_held2", {63'd0, rdy[4]}, 64'd1);
        send(4, PT, 1'b1, CT, a2);
        idle(4);
        chk("b2b_r16_gap_ab", 64'(a1 - a0), 64'd1);
        chk("b2b_r16_gap_bc", 64'(a2 - a1), 64'd1);
        drain();

        // Request mid-block is dropped, not queued.
        send(0, PT, 1'b1, CT, a0);
        idle(0);
        repeat (2) @(negedge clk);
        din[0]    = CT;
        flag[0]   = 1'b0;
        din_en[0] = 1'b1;
        #1;
        chk("busy_rdy_low", {63'd0, rdy[0]}, 64'd0);
        chk("busy_high", {63'd0, busy[0]}, 64'd1);
        @(negedge clk);
        din_en[0] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("busy_hold_%0d", k), {63'd0, busy[0]}, 64'd1);
        end
        drain();

        // Reset mid-block: aborted, nothing emitted, then a clean block.
        send(0, PT, 1'b1, CT, a0);
        idle(0);
        repeat (7) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        sb_q.delete();
        chk("abort_dout", dout[0], 64'd0);
        chk("abort_dout_en", {63'd0, dout_en[0]}, 64'd0);
        chk("abort_rdy", {63'd0, rdy[0]}, 64'd1);
        chk("abort_busy", {63'd0, busy[0]}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        send(0, PT, 1'b1, CT, a0);
        idle(0);
        drain();

`ifdef DES_DPC_PX_KEYLATCH_EN
        // Key swapped right after accept must not affect the block.
        send(0, PT, 1'b1, CT, a0);
        idle(0);
        keyex = '0;
        drain();
        keyex = KEYS;
`endif

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
